// File: rtl/i2c_slave_pkg.sv
// Shared I2C definitions for the slave and master blocks.
// Holds the slave FSM state encoding and the I2C protocol constants
// (ACK/NACK bit levels and the number of data bits per byte).
package i2c_slave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_WR_DATA   = 3'd3,
        ST_WR_ACK    = 3'd4,
        ST_RD_DATA   = 3'd5,
        ST_RD_ACK    = 3'd6,
        ST_WAIT_STOP = 3'd7
    } state_t;

    localparam logic       I2C_ACK       = 1'b0;
    localparam logic       I2C_NACK      = 1'b1;
    localparam logic [3:0] I2C_BYTE_BITS = 4'd8;

endpackage

// File: rtl/i2c_slave_if.sv
// Bus and user-side signal bundle of the I2C slave.
//   scl_in, sda_in : bus line levels (asynchronous to clk)
//   sda_oe         : 1 = pull SDA low, 0 = release
//   tx_data/tx_req : read byte supply; tx_req pulses one clk when the next
//                    byte is needed, tx_data must then stay stable until the
//                    following SCL fall (no ready path, SCL is never stretched)
//   rx_data/rx_valid : written byte, rx_valid pulses one clk per byte
//   busy, stop_det : transaction status
interface i2c_slave_if;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] tx_data;
    logic       tx_req;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       stop_det;

    modport slave (
        input  scl_in, sda_in, tx_data,
        output sda_oe, tx_req, rx_data, rx_valid, busy, stop_det
    );

    modport master (
        output scl_in, sda_in, tx_data,
        input  sda_oe, tx_req, rx_data, rx_valid, busy, stop_det
    );
endinterface

// File: rtl/i2c_slave_sync_edge.sv
// Synchroniser plus edge detector for one asynchronous bus line.
//   clk, rst : system clock, synchronous active-high reset
//   i_line   : asynchronous line level
//   o_level  : synchronised level
//   o_rise   : one-clk pulse on a synchronised 0->1 transition
//   o_fall   : one-clk pulse on a synchronised 1->0 transition
// STAGES must be at least 2. Flops reset to 1 so an idle bus produces no edge.
module i2c_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_line,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '1;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_line};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  = r_sync[STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[STAGES-1] & r_prev;
endmodule

// File: rtl/i2c_slave.sv
// I2C slave with a 7-bit address, byte-wide write receive and read supply.
//   clk, rst    : system clock (>= 8x SCL), synchronous active-high reset
//   bus         : i2c_slave_if.slave (bus lines, tx/rx byte ports, status)
//   o_dbg_state : current FSM state
module i2c_slave
    import i2c_slave_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h55,
    parameter int         SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    i2c_slave_if.slave        bus,
    output state_t            o_dbg_state
);
    logic w_scl, w_scl_rise, w_scl_fall;
    logic w_sda, w_sda_rise, w_sda_fall;
    logic w_start, w_stop;

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl (
        .clk(clk), .rst(rst), .i_line(bus.scl_in),
        .o_level(w_scl), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
    );

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda (
        .clk(clk), .rst(rst), .i_line(bus.sda_in),
        .o_level(w_sda), .o_rise(w_sda_rise), .o_fall(w_sda_fall)
    );

    // Both lines share the same latency, so the synchronised SCL level is
    // the level seen at the moment of the SDA edge.
    assign w_start = w_sda_fall & w_scl;
    assign w_stop  = w_sda_rise & w_scl;

    state_t     r_state,    w_state_nx;
    logic [3:0] r_bit_cnt,  w_bit_cnt_nx;
    logic [7:0] r_shift,    w_shift_nx;
    logic [7:0] r_tx_shift, w_tx_shift_nx;
    logic       r_rw,       w_rw_nx;
    logic       r_sda_oe,   w_sda_oe_nx;
    logic       r_tx_req,   w_tx_req_nx;
    logic [7:0] r_rx_data,  w_rx_data_nx;
    logic       r_rx_valid, w_rx_valid_nx;
    logic       r_busy,     w_busy_nx;
    logic       r_stop_det, w_stop_det_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= 4'd0;
            r_shift    <= 8'h00;
            r_tx_shift <= 8'h00;
            r_rw       <= 1'b0;
            r_sda_oe   <= 1'b0;
            r_tx_req   <= 1'b0;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_stop_det <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_bit_cnt  <= w_bit_cnt_nx;
            r_shift    <= w_shift_nx;
            r_tx_shift <= w_tx_shift_nx;
            r_rw       <= w_rw_nx;
            r_sda_oe   <= w_sda_oe_nx;
            r_tx_req   <= w_tx_req_nx;
            r_rx_data  <= w_rx_data_nx;
            r_rx_valid <= w_rx_valid_nx;
            r_busy     <= w_busy_nx;
            r_stop_det <= w_stop_det_nx;
        end
    end

    // In the ACK states the bit counter tracks the ACK slot: 8 = waiting for
    // the fall that opens it, 0 = waiting for the 9th rise, 1 = waiting for
    // the fall that closes it.
    always_comb begin
        w_state_nx    = r_state;
        w_bit_cnt_nx  = r_bit_cnt;
        w_shift_nx    = r_shift;
        w_tx_shift_nx = r_tx_shift;
        w_rw_nx       = r_rw;
        w_sda_oe_nx   = r_sda_oe;
        w_tx_req_nx   = 1'b0;
        w_rx_data_nx  = r_rx_data;
        w_rx_valid_nx = 1'b0;
        w_busy_nx     = r_busy;
        w_stop_det_nx = 1'b0;

        if (w_stop) begin
            w_state_nx    = ST_IDLE;
            w_bit_cnt_nx  = 4'd0;
            w_shift_nx    = 8'h00;
            w_sda_oe_nx   = 1'b0;
            w_busy_nx     = 1'b0;
            w_stop_det_nx = 1'b1;
        end else if (w_start) begin
            w_state_nx   = ST_ADDR;
            w_bit_cnt_nx = 4'd0;
            w_shift_nx   = 8'h00;
            w_sda_oe_nx  = 1'b0;
        end else begin
            unique case (r_state)
                ST_ADDR: begin
                    if (w_scl_rise) begin
                        w_shift_nx   = {r_shift[6:0], w_sda};
                        w_bit_cnt_nx = r_bit_cnt + 4'd1;
                        if (r_bit_cnt == I2C_BYTE_BITS - 4'd1) begin
                            // r_shift[6:0] holds the 7 address bits, w_sda is R/W.
                            if (r_shift[6:0] == SLAVE_ADDR) begin
                                w_state_nx = ST_ADDR_ACK;
                                w_busy_nx  = 1'b1;
                                w_rw_nx    = w_sda;
                            end else begin
                                w_state_nx = ST_WAIT_STOP;
                                w_busy_nx  = 1'b0;
                            end
                        end
                    end
                end
                ST_ADDR_ACK, ST_WR_ACK: begin
                    if (w_scl_fall && r_bit_cnt == I2C_BYTE_BITS) begin
                        w_sda_oe_nx  = 1'b1;
                        w_bit_cnt_nx = 4'd0;
                    end else if (w_scl_rise && r_bit_cnt == 4'd0) begin
                        w_bit_cnt_nx = 4'd1;
                        if (r_state == ST_ADDR_ACK && r_rw) w_tx_req_nx = 1'b1;
                    end else if (w_scl_fall && r_bit_cnt == 4'd1) begin
                        w_bit_cnt_nx = 4'd0;
                        if (r_state == ST_ADDR_ACK && r_rw) begin
                            w_state_nx    = ST_RD_DATA;
                            w_tx_shift_nx = bus.tx_data;
                            w_sda_oe_nx   = ~bus.tx_data[7];
                        end else begin
                            w_state_nx  = ST_WR_DATA;
                            w_sda_oe_nx = 1'b0;
                            w_shift_nx  = 8'h00;
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (w_scl_rise) begin
                        w_shift_nx   = {r_shift[6:0], w_sda};
                        w_bit_cnt_nx = r_bit_cnt + 4'd1;
                        if (r_bit_cnt == I2C_BYTE_BITS - 4'd1) begin
                            w_rx_data_nx  = {r_shift[6:0], w_sda};
                            w_rx_valid_nx = 1'b1;
                            w_state_nx    = ST_WR_ACK;
                        end
                    end
                end
                ST_RD_DATA: begin
                    // Bit 7 was put on the bus on entry; each later fall
                    // presents the next bit until all 8 have been clocked.
                    if (w_scl_rise && r_bit_cnt < I2C_BYTE_BITS) begin
                        w_bit_cnt_nx = r_bit_cnt + 4'd1;
                    end else if (w_scl_fall && r_bit_cnt == I2C_BYTE_BITS) begin
                        w_sda_oe_nx  = 1'b0;
                        w_state_nx   = ST_RD_ACK;
                        w_bit_cnt_nx = 4'd0;
                    end else if (w_scl_fall && r_bit_cnt != 4'd0) begin
                        w_sda_oe_nx   = ~r_tx_shift[6];
                        w_tx_shift_nx = {r_tx_shift[6:0], 1'b0};
                    end
                end
                ST_RD_ACK: begin
                    if (w_scl_rise && r_bit_cnt == 4'd0) begin
                        if (w_sda == I2C_ACK) begin
                            w_tx_req_nx  = 1'b1;
                            w_bit_cnt_nx = 4'd1;
                        end else begin
                            w_state_nx  = ST_WAIT_STOP;
                            w_sda_oe_nx = 1'b0;
                        end
                    end else if (w_scl_fall && r_bit_cnt == 4'd1) begin
                        w_state_nx    = ST_RD_DATA;
                        w_bit_cnt_nx  = 4'd0;
                        w_tx_shift_nx = bus.tx_data;
                        w_sda_oe_nx   = ~bus.tx_data[7];
                    end
                end
                ST_IDLE, ST_WAIT_STOP: begin
                    w_sda_oe_nx = 1'b0;
                end
                default: begin
                    w_state_nx  = ST_IDLE;
                    w_sda_oe_nx = 1'b0;
                end
            endcase
        end
    end

    assign bus.sda_oe   = r_sda_oe;
    assign bus.tx_req   = r_tx_req;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;
    assign bus.busy     = r_busy;
    assign bus.stop_det = r_stop_det;
    assign o_dbg_state  = r_state;
endmodule
